// File: rtl/rv_g_regfile_pkg.sv
// Shared types, sizes and writeback width rule for the unified RV G register file.
package rv_g_regfile_pkg;

  localparam int unsigned ADDR_W        = 6;
  localparam int unsigned NUM_REGS      = 64;
  localparam int unsigned FP_BASE       = 32;
  localparam int unsigned WB_MAX_W      = 64;
  // Read-side address ports: rs1, rs2, rs3 carry data; rd only needs a hazard check.
  localparam int unsigned NUM_SRC_PORTS = 3;
  localparam int unsigned NUM_RD_PORTS  = 4;

  typedef logic [ADDR_W-1:0] reg_addr_t;

  // Upper half of the address space holds the FP registers.
  function automatic logic is_fp(input reg_addr_t addr);
    return addr >= reg_addr_t'(FP_BASE);
  endfunction

  // Keep XLEN bits for integer targets, FLEN bits for FP targets, zero the rest.
  function automatic logic [WB_MAX_W-1:0] wb_extend(input reg_addr_t           addr,
                                                    input logic [WB_MAX_W-1:0] data,
                                                    input int unsigned         xlen,
                                                    input int unsigned         flen);
    int unsigned         len;
    logic [WB_MAX_W-1:0] mask;
    len  = is_fp(addr) ? flen : xlen;
    mask = (len >= WB_MAX_W) ? '1 : ((WB_MAX_W'(1) << len) - WB_MAX_W'(1));
    return data & mask;
  endfunction

endpackage

// File: rtl/rv_g_regfile_wb_merge.sv
// Folds NUM_WR writeback ports into per-register write/clear vectors and
// per-read-port forwarding hits; the highest-index matching port wins.
module rv_g_regfile_wb_merge
  import rv_g_regfile_pkg::*;
#(
  parameter int unsigned NUM_WR = 2,
  parameter int unsigned MaxLen = 32
) (
  input  logic [NUM_WR*ADDR_W-1:0]                   wr_addr,
  input  logic [NUM_WR*MaxLen-1:0]                   wr_data,
  input  logic [NUM_WR-1:0]                          wr_en,
  input  logic [NUM_RD_PORTS*ADDR_W-1:0]             rd_addr,
  output logic [NUM_REGS-1:0]                        reg_we,
  output logic [NUM_REGS-1:0][MaxLen-1:0]            reg_data,
  output logic [NUM_REGS-1:0]                        lock_clr,
  output logic [NUM_RD_PORTS-1:0]                    fwd_hit,
  output logic [NUM_SRC_PORTS-1:0][MaxLen-1:0]       fwd_data
);

  reg_addr_t wa;

  // Later ports overwrite earlier ones, giving highest-index priority.
  always_comb begin
    reg_we   = '0;
    reg_data = '0;
    lock_clr = '0;
    fwd_hit  = '0;
    fwd_data = '0;
    wa       = '0;
    for (int p = 0; p < int'(NUM_WR); p++) begin
      if (wr_en[p]) begin
        wa           = wr_addr[p*ADDR_W +: ADDR_W];
        lock_clr[wa] = 1'b1;
        if (wa != '0) begin
          reg_we[wa]   = 1'b1;
          reg_data[wa] = wr_data[p*MaxLen +: MaxLen];
        end
        for (int k = 0; k < int'(NUM_RD_PORTS); k++) begin
          if (rd_addr[k*ADDR_W +: ADDR_W] == wa) begin
            fwd_hit[k] = 1'b1;
            if (k < int'(NUM_SRC_PORTS)) begin
              fwd_data[k] = wr_data[p*MaxLen +: MaxLen];
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/rv_g_regfile_mw.sv
// Unified 32 int + 32 FP register file with lock scoreboard, req/gnt issue
// and NUM_WR writeback ports.
module rv_g_regfile_mw
  import rv_g_regfile_pkg::*;
#(
  parameter int unsigned XLEN             = 32,
  parameter int unsigned FLEN             = 32,
  parameter int unsigned NUM_WR           = 2,
  parameter bit          ALLOW_FORWARDING = 1'b0,
  localparam int unsigned MaxLen          = (XLEN > FLEN) ? XLEN : FLEN
) (
  input  logic                       clk_i,
  input  logic                       arst_ni,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr_i,
  input  logic [NUM_WR*MaxLen-1:0]   wr_data_i,
  input  logic [NUM_WR-1:0]          wr_en_i,
  input  logic                       flush_i,
  input  logic [ADDR_W-1:0]          rd_addr_i,
  input  logic [ADDR_W-1:0]          rs1_addr_i,
  input  logic [ADDR_W-1:0]          rs2_addr_i,
  input  logic [ADDR_W-1:0]          rs3_addr_i,
  input  logic                       req_i,
  output logic [MaxLen-1:0]          rs1_data_o,
  output logic [MaxLen-1:0]          rs2_data_o,
  output logic [MaxLen-1:0]          rs3_data_o,
  output logic                       gnt_o,
  output logic [NUM_REGS-1:0]        lock_o
);

  logic [NUM_WR*MaxLen-1:0]                wb_data;
  logic [NUM_RD_PORTS*ADDR_W-1:0]          rd_addr_all;
  logic [NUM_REGS-1:0]                     reg_we;
  logic [NUM_REGS-1:0][MaxLen-1:0]         reg_data;
  logic [NUM_REGS-1:0]                     lock_clr;
  logic [NUM_RD_PORTS-1:0]                 fwd_hit;
  logic [NUM_SRC_PORTS-1:0][MaxLen-1:0]    fwd_data;
  logic [NUM_REGS-1:0][MaxLen-1:0]         regs_q;
  logic [NUM_REGS-1:0]                     lock_q;
  logic [NUM_REGS-1:0]                     lock_d;
  logic [NUM_RD_PORTS-1:0]                 blocked;
  logic [NUM_SRC_PORTS-1:0][MaxLen-1:0]    src_data;
  logic [NUM_RD_PORTS-1:0]                 fwd_use;
  reg_addr_t                               ra;

  assign rd_addr_all = {rd_addr_i, rs3_addr_i, rs2_addr_i, rs1_addr_i};

  // Apply the int/FP width rule to each port before merging.
  always_comb begin
    wb_data = '0;
    for (int p = 0; p < int'(NUM_WR); p++) begin
      wb_data[p*MaxLen +: MaxLen] = MaxLen'(wb_extend(wr_addr_i[p*ADDR_W +: ADDR_W],
                                                      WB_MAX_W'(wr_data_i[p*MaxLen +: MaxLen]),
                                                      XLEN, FLEN));
    end
  end

  rv_g_regfile_wb_merge #(
    .NUM_WR (NUM_WR),
    .MaxLen (MaxLen)
  ) u_wb_merge (
    .wr_addr  (wr_addr_i),
    .wr_data  (wb_data),
    .wr_en    (wr_en_i),
    .rd_addr  (rd_addr_all),
    .reg_we   (reg_we),
    .reg_data (reg_data),
    .lock_clr (lock_clr),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data)
  );

  // Operand reads and hazard detection; x0 and reset both read as zero.
  always_comb begin
    src_data = '0;
    blocked  = '0;
    fwd_use  = ALLOW_FORWARDING ? fwd_hit : '0;
    ra       = '0;
    for (int k = 0; k < int'(NUM_RD_PORTS); k++) begin
      ra         = rd_addr_all[k*ADDR_W +: ADDR_W];
      blocked[k] = lock_q[ra] & ~fwd_use[k];
      if (k < int'(NUM_SRC_PORTS)) begin
        if (!arst_ni || ra == '0) begin
          src_data[k] = '0;
        end else if (fwd_use[k]) begin
          src_data[k] = fwd_data[k];
        end else begin
          src_data[k] = regs_q[ra];
        end
      end
    end
  end

  assign rs1_data_o = src_data[0];
  assign rs2_data_o = src_data[1];
  assign rs3_data_o = src_data[2];
  assign gnt_o      = arst_ni & req_i & ~flush_i & ~(|blocked);

  // Next lock state: writeback clears, then grant sets, then flush clears all.
  always_comb begin
    lock_d = lock_q & ~lock_clr;
    if (gnt_o && rd_addr_i != '0) begin
      lock_d[rd_addr_i] = 1'b1;
    end
    if (flush_i) begin
      lock_d = '0;
    end
  end

  // Register array storage; x0 is never enabled by the merge.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      regs_q <= '0;
    end else begin
      for (int r = 0; r < int'(NUM_REGS); r++) begin
        if (reg_we[r]) begin
          regs_q[r] <= reg_data[r];
        end
      end
    end
  end

  // Lock scoreboard register.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      lock_q <= '0;
    end else begin
      lock_q <= lock_d;
    end
  end

  assign lock_o = lock_q;

endmodule

// File: tb/tb_rv_g_regfile_mw.sv
// Bench for rv_g_regfile_mw: a forwarding and a non-forwarding instance
// (XLEN=32, FLEN=64, NUM_WR=2) share stimulus and are checked side by side.
module tb_rv_g_regfile_mw;

  localparam int unsigned ML = 64;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic [1:0]  wen;
    logic [5:0]  wa0;
    logic [63:0] wd0;
    logic [5:0]  wa1;
    logic [63:0] wd1;
    logic        req;
    logic [5:0]  rd;
    logic [5:0]  rs1;
    logic [5:0]  rs2;
    logic [5:0]  rs3;
    logic        flush;
  } in_t;

  typedef struct {
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] rs3;
    logic        gnt;
    logic [63:0] lock;
  } out_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  o;
  } vec_t;

  typedef struct {
    string       name;
    int          sig;
    logic [63:0] exp;
  } sb_t;

  logic          clk = 1'b0;
  logic          arst_ni = 1'b0;
  logic [11:0]   wr_addr = '0;
  logic [127:0]  wr_data = '0;
  logic [1:0]    wr_en = '0;
  logic          flush = 1'b0;
  logic [5:0]    rd_addr = '0;
  logic [5:0]    rs1_addr = '0;
  logic [5:0]    rs2_addr = '0;
  logic [5:0]    rs3_addr = '0;
  logic          req = 1'b0;

  logic [ML-1:0] rs1_f, rs2_f, rs3_f, rs1_n, rs2_n, rs3_n;
  logic          gnt_f, gnt_n;
  logic [63:0]   lock_f, lock_n;

  int total = 0;
  int bad = 0;
  sb_t  sb_q[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  rv_g_regfile_mw #(.XLEN(32), .FLEN(64), .NUM_WR(2), .ALLOW_FORWARDING(1'b1)) dut_f (
    .clk_i(clk), .arst_ni(arst_ni), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .wr_en_i(wr_en), .flush_i(flush), .rd_addr_i(rd_addr), .rs1_addr_i(rs1_addr),
    .rs2_addr_i(rs2_addr), .rs3_addr_i(rs3_addr), .req_i(req),
    .rs1_data_o(rs1_f), .rs2_data_o(rs2_f), .rs3_data_o(rs3_f),
    .gnt_o(gnt_f), .lock_o(lock_f)
  );

  rv_g_regfile_mw #(.XLEN(32), .FLEN(64), .NUM_WR(2), .ALLOW_FORWARDING(1'b0)) dut_n (
    .clk_i(clk), .arst_ni(arst_ni), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .wr_en_i(wr_en), .flush_i(flush), .rd_addr_i(rd_addr), .rs1_addr_i(rs1_addr),
    .rs2_addr_i(rs2_addr), .rs3_addr_i(rs3_addr), .req_i(req),
    .rs1_data_o(rs1_n), .rs2_data_o(rs2_n), .rs3_data_o(rs3_n),
    .gnt_o(gnt_n), .lock_o(lock_n)
  );

  function automatic logic [63:0] b(input int n);
    return 64'd1 << n;
  endfunction

  function automatic in_t mi(input int wen, input int wa0, input logic [63:0] wd0,
                             input int wa1, input logic [63:0] wd1, input int rq,
                             input int rd, input int s1, input int s2, input int s3,
                             input int fl);
    in_t r;
    r.wen = 2'(wen); r.wa0 = 6'(wa0); r.wd0 = wd0; r.wa1 = 6'(wa1); r.wd1 = wd1;
    r.req = (rq != 0); r.rd = 6'(rd); r.rs1 = 6'(s1); r.rs2 = 6'(s2); r.rs3 = 6'(s3);
    r.flush = (fl != 0);
    return r;
  endfunction

  function automatic out_t mo(input logic [63:0] e1, input logic [63:0] e2,
                              input logic [63:0] e3, input int g, input logic [63:0] lk);
    out_t r;
    r.rs1 = e1; r.rs2 = e2; r.rs3 = e3; r.gnt = (g != 0); r.lock = lk;
    return r;
  endfunction

  function automatic vec_t mv(input string nm, input in_t i, input out_t o);
    vec_t v;
    v.name = nm; v.i = i; v.o = o;
    return v;
  endfunction

  function automatic logic [63:0] act(input int s);
    case (s)
      0: return rs1_f;
      1: return rs2_f;
      2: return rs3_f;
      3: return 64'(gnt_f);
      4: return lock_f;
      5: return rs1_n;
      6: return rs2_n;
      7: return rs3_n;
      8: return 64'(gnt_n);
      default: return lock_n;
    endcase
  endfunction

  task automatic apply(input in_t i);
    wr_en    = i.wen;
    wr_addr  = {i.wa1, i.wa0};
    wr_data  = {i.wd1, i.wd0};
    req      = i.req;
    rd_addr  = i.rd;
    rs1_addr = i.rs1;
    rs2_addr = i.rs2;
    rs3_addr = i.rs3;
    flush    = i.flush;
  endtask

  task automatic push(input string nm, input int s, input logic [63:0] e);
    sb_t x;
    x.name = nm; x.sig = s; x.exp = e;
    sb_q.push_back(x);
  endtask

  task automatic expect_out(input string nm, input out_t ef, input out_t en);
    push({nm, ".fwd.rs1"}, 0, ef.rs1);
    push({nm, ".fwd.rs2"}, 1, ef.rs2);
    push({nm, ".fwd.rs3"}, 2, ef.rs3);
    push({nm, ".fwd.gnt"}, 3, 64'(ef.gnt));
    push({nm, ".fwd.lock"}, 4, ef.lock);
    push({nm, ".nofwd.rs1"}, 5, en.rs1);
    push({nm, ".nofwd.rs2"}, 6, en.rs2);
    push({nm, ".nofwd.rs3"}, 7, en.rs3);
    push({nm, ".nofwd.gnt"}, 8, 64'(en.gnt));
    push({nm, ".nofwd.lock"}, 9, en.lock);
  endtask

  task automatic drain();
    sb_t         x;
    logic [63:0] a;
    while (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      a = act(x.sig);
      total++;
      if (a !== x.exp) begin
        bad++;
        $display("FAIL %s: got %h expected %h", x.name, a, x.exp);
      end
    end
  endtask

  // One cycle: drive at the falling edge, compare 1 time unit later.
  task automatic run(input string nm, input in_t i, input out_t ef, input out_t en);
    @(negedge clk);
    apply(i);
    expect_out(nm, ef, en);
    #1;
    drain();
  endtask

  initial begin
    // Reset state: grant forced low, reads and locks zero.
    apply(mi(0, 0, 0, 0, 0, 1, 0, 5, 37, 63, 0));
    #1;
    expect_out("in_reset", mo(0, 0, 0, 0, 0), mo(0, 0, 0, 0, 0));
    drain();
    @(negedge clk);
    arst_ni = 1'b1;

    for (int a = 0; a < 64; a++) begin
      run($sformatf("rst_rd%0d", a), mi(0, 0, 0, 0, 0, 1, 0, a, a, a, 0),
          mo(0, 0, 0, 1, 0), mo(0, 0, 0, 1, 0));
    end

    tbl.push_back(mv("wr5_37",    mi(3, 5, ONES, 37, ONES, 0, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 0)));
    tbl.push_back(mv("rd_wext",   mi(0, 0, 0, 0, 0, 1, 7, 5, 37, 0, 0), mo(64'hFFFF_FFFF, ONES, 0, 1, 0)));
    tbl.push_back(mv("dep_rs2",   mi(0, 0, 0, 0, 0, 1, 0, 0, 7, 0, 0), mo(0, 0, 0, 0, b(7))));
    tbl.push_back(mv("lock10",    mi(0, 0, 0, 0, 0, 1, 10, 0, 0, 0, 0), mo(0, 0, 0, 1, 0)));
    tbl.push_back(mv("same_addr", mi(3, 10, 64'h11, 10, 64'h22, 0, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, b(10))));
    tbl.push_back(mv("rd10",      mi(0, 0, 0, 0, 0, 0, 0, 10, 0, 0, 0), mo(64'h22, 0, 0, 0, 0)));
    tbl.push_back(mv("set_wins",  mi(1, 12, 64'h5A, 0, 0, 1, 12, 0, 0, 0, 0), mo(0, 0, 0, 1, 0)));
    tbl.push_back(mv("chk12",     mi(0, 0, 0, 0, 0, 0, 0, 12, 0, 0, 0), mo(64'h5A, 0, 0, 0, b(12))));
    tbl.push_back(mv("lk3",       mi(0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0), mo(0, 0, 0, 1, b(12))));
    tbl.push_back(mv("lk40",      mi(0, 0, 0, 0, 0, 1, 40, 0, 0, 0, 0), mo(0, 0, 0, 1, b(12) | b(3))));
    tbl.push_back(mv("lk63",      mi(0, 0, 0, 0, 0, 1, 63, 0, 0, 0, 0), mo(0, 0, 0, 1, b(12) | b(3) | b(40))));
    tbl.push_back(mv("flush",     mi(0, 0, 0, 0, 0, 1, 5, 5, 0, 0, 1),
                     mo(64'hFFFF_FFFF, 0, 0, 0, b(12) | b(3) | b(40) | b(63))));
    tbl.push_back(mv("post_flush", mi(0, 0, 0, 0, 0, 0, 0, 5, 37, 10, 0), mo(64'hFFFF_FFFF, ONES, 64'h22, 0, 0)));
    tbl.push_back(mv("flush_wr",  mi(1, 20, 64'h77, 0, 0, 0, 0, 0, 0, 0, 1), mo(0, 0, 0, 0, 0)));
    tbl.push_back(mv("rd20",      mi(0, 0, 0, 0, 0, 0, 0, 20, 0, 0, 0), mo(64'h77, 0, 0, 0, 0)));
    tbl.push_back(mv("x0_wr",     mi(1, 0, 64'h99, 0, 0, 1, 0, 0, 0, 0, 0), mo(0, 0, 0, 1, 0)));
    tbl.push_back(mv("x0_rd",     mi(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), mo(0, 0, 0, 1, 0)));
    tbl.push_back(mv("fp_narrow", mi(3, 33, 64'h1234_5678_9ABC_DEF0, 6, 64'h1234_5678_9ABC_DEF0, 0, 0, 0, 0, 0, 0),
                     mo(0, 0, 0, 0, 0)));
    tbl.push_back(mv("rd_narrow", mi(0, 0, 0, 0, 0, 0, 0, 33, 6, 0, 0),
                     mo(64'h1234_5678_9ABC_DEF0, 64'h9ABC_DEF0, 0, 0, 0)));
    tbl.push_back(mv("lk20",      mi(0, 0, 0, 0, 0, 1, 20, 0, 0, 0, 0), mo(0, 0, 0, 1, 0)));
    tbl.push_back(mv("waw20",     mi(0, 0, 0, 0, 0, 1, 20, 0, 0, 0, 0), mo(0, 0, 0, 0, b(20))));
    tbl.push_back(mv("raw_rs1",   mi(0, 0, 0, 0, 0, 1, 0, 20, 0, 0, 0), mo(64'h77, 0, 0, 0, b(20))));
    tbl.push_back(mv("raw_rs3",   mi(0, 0, 0, 0, 0, 1, 0, 0, 0, 20, 0), mo(0, 0, 64'h77, 0, b(20))));
    tbl.push_back(mv("noreq",     mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, b(20))));

    for (int k = 0; k < 3; k++) run(tbl[k].name, tbl[k].i, tbl[k].o, tbl[k].o);

    // Writeback to locked x7 on port 1: forwarding grants now, the other next cycle.
    run("h1_wb", mi(2, 0, 0, 7, 64'hAB, 1, 0, 0, 7, 0, 0),
        mo(0, 64'hAB, 0, 1, b(7)), mo(0, 0, 0, 0, b(7)));
    run("h1_next", mi(0, 0, 0, 0, 0, 1, 0, 0, 7, 0, 0),
        mo(0, 64'hAB, 0, 1, 0), mo(0, 64'hAB, 0, 1, 0));

    for (int k = 3; k < tbl.size(); k++) run(tbl[k].name, tbl[k].i, tbl[k].o, tbl[k].o);

    // Forwarded writeback unblocks rd and rs1; the re-lock beats the clear.
    run("h2_fwd", mi(1, 20, 64'h55, 0, 0, 1, 20, 20, 0, 0, 0),
        mo(64'h55, 0, 0, 1, b(20)), mo(64'h77, 0, 0, 0, b(20)));
    run("h2_after", mi(0, 0, 0, 0, 0, 0, 0, 20, 0, 0, 0),
        mo(64'h55, 0, 0, 0, b(20)), mo(64'h55, 0, 0, 0, 0));
    run("h2_flush", mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1),
        mo(0, 0, 0, 0, b(20)), mo(0, 0, 0, 0, 0));

    // Mid-operation reset wipes data and locks immediately.
    run("h3_lock", mi(0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0), mo(0, 0, 0, 1, 0), mo(0, 0, 0, 1, 0));
    run("h3_pre", mi(0, 0, 0, 0, 0, 1, 0, 5, 9, 0, 0),
        mo(64'hFFFF_FFFF, 0, 0, 0, b(9)), mo(64'hFFFF_FFFF, 0, 0, 0, b(9)));
    #1;
    arst_ni = 1'b0;
    #1;
    expect_out("h3_rst", mo(0, 0, 0, 0, 0), mo(0, 0, 0, 0, 0));
    drain();
    @(negedge clk);
    arst_ni = 1'b1;
    run("h3_post", mi(0, 0, 0, 0, 0, 1, 0, 5, 9, 37, 0), mo(0, 0, 0, 1, 0), mo(0, 0, 0, 1, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
